// File: rtl/pixel_write_arbiter.sv
// Shares the single VGA pixel-write port between a full-screen clear sweep,
// the food spawner and the snake engine (clear first, then food/snake round-robin).
module pixel_write_arbiter #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic       clk,
  input  logic       reset_n,

  input  logic       clear_start,
  input  logic [2:0] clear_colour,
  output logic       clear_busy,
  output logic       clear_done,

  input  logic       food_req,
  input  logic [7:0] food_x,
  input  logic [6:0] food_y,
  input  logic [2:0] food_colour,
  output logic       food_gnt,

  input  logic       snake_req,
  input  logic [7:0] snake_x,
  input  logic [6:0] snake_y,
  input  logic [2:0] snake_colour,
  output logic       snake_gnt,

  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam logic [7:0] X_LAST  = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST  = 7'(HEIGHT - 1);
  localparam logic [8:0] X_LIMIT = 9'(WIDTH);
  localparam logic [7:0] Y_LIMIT = 8'(HEIGHT);

  state_t     state;
  state_t     next_state;
  logic [7:0] cx;
  logic [6:0] cy;
  logic [2:0] fill_colour;
  logic       last_snake;
  logic       sweep_last;
  logic       food_in_range;
  logic       snake_in_range;

  assign sweep_last     = (cx == X_LAST) && (cy == Y_LAST);
  assign food_in_range  = ({1'b0, food_x} < X_LIMIT) && ({1'b0, food_y} < Y_LIMIT);
  assign snake_in_range = ({1'b0, snake_x} < X_LIMIT) && ({1'b0, snake_y} < Y_LIMIT);
  assign clear_busy     = (state == CLEAR);

  // On a tie the requester that was not served last wins.
  always_comb begin
    next_state = state;
    food_gnt   = 1'b0;
    snake_gnt  = 1'b0;
    case (state)
      IDLE: begin
        if (food_req && (!snake_req || last_snake)) begin
          food_gnt = 1'b1;
        end else if (snake_req) begin
          snake_gnt = 1'b1;
        end
        if (clear_start) begin
          next_state = CLEAR;
        end
      end
      CLEAR: begin
        if (sweep_last) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cx          <= '0;
      cy          <= '0;
      fill_colour <= '0;
    end else if (state == IDLE) begin
      if (clear_start) begin
        cx          <= '0;
        cy          <= '0;
        fill_colour <= clear_colour;
      end
    end else if (cx == X_LAST) begin
      cx <= '0;
      cy <= cy + 7'd1;
    end else begin
      cx <= cx + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_snake <= 1'b1;
    end else if (food_gnt) begin
      last_snake <= 1'b0;
    end else if (snake_gnt) begin
      last_snake <= 1'b1;
    end
  end

  // Out-of-range pixels are consumed and shown on the bus, but never plotted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= (state == CLEAR) && sweep_last;
      if (state == CLEAR) begin
        vga_x      <= cx;
        vga_y      <= cy;
        vga_colour <= fill_colour;
        vga_plot   <= 1'b1;
      end else if (food_gnt) begin
        vga_x      <= food_x;
        vga_y      <= food_y;
        vga_colour <= food_colour;
        vga_plot   <= food_in_range;
      end else if (snake_gnt) begin
        vga_x      <= snake_x;
        vga_y      <= snake_y;
        vga_colour <= snake_colour;
        vga_plot   <= snake_in_range;
      end else begin
        vga_plot   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Randomised and directed bench for pixel_write_arbiter against a pixel-index
// level reference model of the clear sweep and food/snake round-robin.
module tb_pixel_write_arbiter;

  localparam int W    = 160;
  localparam int H    = 120;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear_start = 1'b0;
  logic [2:0] clear_colour = '0;
  logic       clear_busy;
  logic       clear_done;
  logic       food_req = 1'b0;
  logic [7:0] food_x = '0;
  logic [6:0] food_y = '0;
  logic [2:0] food_colour = '0;
  logic       food_gnt;
  logic       snake_req = 1'b0;
  logic [7:0] snake_x = '0;
  logic [6:0] snake_y = '0;
  logic [2:0] snake_colour = '0;
  logic       snake_gnt;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int compareCount = 0;
  int mismatchCount = 0;

  // Reference model state: the sweep is a linear pixel index.
  bit         mClearing;
  int         mIdx;
  logic [2:0] mColour;
  bit         mLastFood;
  logic [7:0] eX;
  logic [6:0] eY;
  logic [2:0] eCol;
  bit         ePlot;
  bit         eDone;
  bit         eFoodGnt;
  bit         eSnakeGnt;

  pixel_write_arbiter #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset_n(reset_n),
    .clear_start(clear_start), .clear_colour(clear_colour),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .food_req(food_req), .food_x(food_x), .food_y(food_y),
    .food_colour(food_colour), .food_gnt(food_gnt),
    .snake_req(snake_req), .snake_x(snake_x), .snake_y(snake_y),
    .snake_colour(snake_colour), .snake_gnt(snake_gnt),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mClearing = 0; mIdx = 0; mColour = '0; mLastFood = 0;
    eX = '0; eY = '0; eCol = '0; ePlot = 0; eDone = 0;
  endtask

  task automatic checkRegs();
    checkOutput("vga_x", 32'(vga_x), 32'(eX));
    checkOutput("vga_y", 32'(vga_y), 32'(eY));
    checkOutput("vga_colour", 32'(vga_colour), 32'(eCol));
    checkOutput("vga_plot", 32'(vga_plot), 32'(ePlot));
    checkOutput("clear_busy", 32'(clear_busy), 32'(mClearing));
    checkOutput("clear_done", 32'(clear_done), 32'(eDone));
  endtask

  // Drives one cycle starting just after a rising edge, checks grants mid-cycle
  // and registered outputs just after the next rising edge.
  task automatic applyStimulus(input bit fr, input logic [7:0] fx, input logic [6:0] fy,
                               input logic [2:0] fc, input bit sr, input logic [7:0] sx,
                               input logic [6:0] sy, input logic [2:0] sc,
                               input bit cs, input logic [2:0] cc);
    food_req = fr; food_x = fx; food_y = fy; food_colour = fc;
    snake_req = sr; snake_x = sx; snake_y = sy; snake_colour = sc;
    clear_start = cs; clear_colour = cc;
    eFoodGnt = 0; eSnakeGnt = 0;
    if (!mClearing) begin
      if (fr && sr) begin
        if (mLastFood) eSnakeGnt = 1; else eFoodGnt = 1;
      end else begin
        eFoodGnt = fr;
        eSnakeGnt = sr;
      end
    end
    @(negedge clk);
    checkOutput("food_gnt", 32'(food_gnt), 32'(eFoodGnt));
    checkOutput("snake_gnt", 32'(snake_gnt), 32'(eSnakeGnt));
    @(posedge clk);
    eDone = 0;
    if (mClearing) begin
      eX = 8'(mIdx % W); eY = 7'(mIdx / W); eCol = mColour; ePlot = 1;
      eDone = (mIdx == NPIX - 1);
      mIdx++;
      if (mIdx == NPIX) mClearing = 0;
    end else begin
      if (eFoodGnt) begin
        eX = fx; eY = fy; eCol = fc; ePlot = (int'(fx) < W) && (int'(fy) < H);
        mLastFood = 1;
      end else if (eSnakeGnt) begin
        eX = sx; eY = sy; eCol = sc; ePlot = (int'(sx) < W) && (int'(sy) < H);
        mLastFood = 0;
      end else begin
        ePlot = 0;
      end
      if (cs) begin
        mClearing = 1; mIdx = 0; mColour = cc;
      end
    end
    #1;
    checkRegs();
  endtask

  task automatic idleCycle();
    applyStimulus(0, '0, '0, '0, 0, '0, '0, '0, 0, '0);
  endtask

  function automatic logic [7:0] randX();
    if ($urandom_range(0, 9) == 0) return 8'($urandom_range(W, 255));
    return 8'($urandom_range(0, W - 1));
  endfunction

  function automatic logic [6:0] randY();
    if ($urandom_range(0, 9) == 0) return 7'($urandom_range(H, 127));
    return 7'($urandom_range(0, H - 1));
  endfunction

  initial begin
    int busyCycles;
    bit fPend, sPend, usedClear, cs;
    logic [7:0] fx, sx;
    logic [6:0] fy, sy;
    logic [2:0] fc, sc;

    modelReset();
    #1;
    checkRegs();
    checkOutput("reset_food_gnt", 32'(food_gnt), 32'd0);
    checkOutput("reset_snake_gnt", 32'(snake_gnt), 32'd0);
    #9 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single food write, then the bus holds with plot low.
    applyStimulus(1, 8'd85, 7'd55, 3'b100, 0, '0, '0, '0, 0, '0);
    checkOutput("t1_vga_x", 32'(vga_x), 32'd85);
    checkOutput("t1_vga_y", 32'(vga_y), 32'd55);
    checkOutput("t1_plot", 32'(vga_plot), 32'd1);
    idleCycle();
    checkOutput("t1_hold_x", 32'(vga_x), 32'd85);

    // Out-of-range snake pixel, then normal food and snake writes.
    applyStimulus(0, '0, '0, '0, 1, 8'd160, 7'd60, 3'b010, 0, '0);
    checkOutput("oor_plot", 32'(vga_plot), 32'd0);
    applyStimulus(1, 8'd12, 7'd34, 3'b001, 0, '0, '0, '0, 0, '0);
    applyStimulus(0, '0, '0, '0, 1, 8'd10, 7'd20, 3'b101, 0, '0);

    // Both requesting: F,S,F,S.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 8'd1, 7'd2, 3'b001, 1, 8'd3, 7'd4, 3'b010, 0, '0);
      checkOutput("rr_x", 32'(vga_x), (i % 2 == 0) ? 32'd1 : 32'd3);
    end

    // Clear together with a food request; snake held through the sweep.
    applyStimulus(1, 8'd50, 7'd50, 3'b111, 0, '0, '0, '0, 1, 3'b000);
    busyCycles = int'(clear_busy);
    for (int i = 0; i < NPIX + 2 && mClearing; i++) begin
      applyStimulus(0, '0, '0, '0, 1, 8'd7, 7'd8, 3'b110, i % 97 == 0, 3'b011);
      busyCycles += int'(clear_busy);
    end
    checkOutput("sweep_length", 32'(busyCycles), 32'(NPIX));
    checkOutput("done_x", 32'(vga_x), 32'(W - 1));
    checkOutput("done_y", 32'(vga_y), 32'(H - 1));
    applyStimulus(0, '0, '0, '0, 1, 8'd7, 7'd8, 3'b110, 0, '0);

    // Reset asserted mid-sweep at pixel 5000.
    applyStimulus(0, '0, '0, '0, 0, '0, '0, '0, 1, 3'b101);
    for (int i = 0; i < NPIX && mClearing && mIdx < 5000; i++) idleCycle();
    #2 reset_n = 1'b0;
    #1;
    modelReset();
    checkRegs();
    @(negedge clk);
    @(posedge clk);
    #1;
    checkRegs();
    #2 reset_n = 1'b1;
    #1;
    applyStimulus(1, 8'd99, 7'd9, 3'b011, 0, '0, '0, '0, 0, '0);
    idleCycle();

    // Randomised traffic with held requests and one more sweep.
    fPend = 0; sPend = 0; usedClear = 0;
    fx = '0; fy = '0; fc = '0; sx = '0; sy = '0; sc = '0;
    for (int i = 0; i < 4000 || mClearing; i++) begin
      if (!fPend) begin
        fPend = ($urandom_range(0, 1) == 1);
        fx = randX(); fy = randY(); fc = 3'($urandom);
      end
      if (!sPend) begin
        sPend = ($urandom_range(0, 2) != 0);
        sx = randX(); sy = randY(); sc = 3'($urandom);
      end
      cs = mClearing ? ($urandom_range(0, 7) == 0)
                     : (!usedClear && i > 1000 && $urandom_range(0, 299) == 0);
      if (cs && !mClearing) usedClear = 1;
      applyStimulus(fPend, fx, fy, fc, sPend, sx, sy, sc, cs, 3'($urandom));
      if (eFoodGnt) fPend = 0;
      if (eSnakeGnt) sPend = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/pixel_write_arbiter.md
# pixel_write_arbiter

Sequences and shares the single VGA adapter pixel-write port (x, y, colour, plot) between the snake draw/erase engine, the food spawner and a built-in full-screen clear sequencer. It sits between the game datapath and `vga_adapter`, and replaces the ad-hoc combinational food/snake pixel mux. It issues at most one pixel write per clock, gives the clear sweep absolute priority, and round-robins between food and snake.

## Interface
- `WIDTH`, default 160: screen width in pixels; x range 0..WIDTH-1.
- `HEIGHT`, default 120: screen height in pixels; y range 0..HEIGHT-1.

- `clk` in 1: system clock, CLOCK_50.
- `reset_n` in 1: asynchronous, active-low reset.
- `clear_start` in 1: single-cycle request to sweep the whole screen.
- `clear_colour` in 3: fill colour, latched when the sweep starts.
- `clear_busy` out 1: high while the sweep is in progress.
- `clear_done` out 1: one-cycle pulse when the sweep completes.
- `food_req` in 1: food write request, held until granted.
- `food_x` / `food_y` / `food_colour` in 8/7/3: food pixel.
- `food_gnt` out 1: combinational grant for food, same cycle as the request.
- `snake_req` in 1: snake write request, held until granted.
- `snake_x` / `snake_y` / `snake_colour` in 8/7/3: snake pixel.
- `snake_gnt` out 1: combinational grant for snake.
- `vga_x` out 8, `vga_y` out 7, `vga_colour` out 3: registered pixel output to the adapter.
- `vga_plot` out 1: registered write strobe to the adapter.

## Operation
- FSM with two states:
  - IDLE: grants food and snake requests.
  - CLEAR: sweeps the screen; `food_gnt` and `snake_gnt` are held at 0.
- IDLE -> CLEAR on `clear_start`=1 at a clock edge:
  - latch `clear_colour`;
  - set the counters cx=0, cy=0.
- `clear_start` is ignored while in CLEAR.
- CLEAR, each cycle:
  - emit pixel (cx, cy, latched colour) with plot=1;
  - cx increments; at cx=WIDTH-1, cx wraps to 0 and cy increments.
- After emitting (WIDTH-1, HEIGHT-1), return to IDLE and pulse `clear_done`.
- A full sweep takes exactly WIDTH*HEIGHT cycles (19200 at default).
- `clear_busy` = (state==CLEAR).
- Arbitration in IDLE:
  - only one requester active: it is granted;
  - both active: grant the one not granted last;
  - the `last` pointer updates only on a grant.
- Grant handshake:
  - the requester samples gnt during the request cycle;
  - it may advance to its next pixel at that clock edge;
  - req may stay high continuously, giving back-to-back writes.
- Granted pixel: on the next edge it is registered to `vga_x`/`vga_y`/`vga_colour` with `vga_plot`=1.
- Out-of-range pixel (x>=WIDTH or y>=HEIGHT):
  - still granted (consumed);
  - `vga_x`/`vga_y`/`vga_colour` update, but `vga_plot`=0 for that cycle.
- No grant and not in CLEAR: `vga_plot`=0; `vga_x`/`vga_y`/`vga_colour` hold their last values.
- `clear_start` in the same IDLE cycle as a request:
  - the request is granted in that cycle;
  - CLEAR begins on the next cycle.

## Timing
- Reset values:
  - state IDLE, `last` = snake (food wins the first tie);
  - cx=cy=0, latched colour 0;
  - all outputs 0: vga_x/y/colour, vga_plot, clear_done, clear_busy, and both gnts (combinationally, since state is IDLE with req=0).
- Latency: request granted in cycle N -> pixel on vga_* with plot=1 in cycle N+1.
- Throughput: one pixel per cycle.
- Clear start:
  - `clear_start` sampled at the edge ending cycle N;
  - `clear_busy`=1 from cycle N+1;
  - first clear pixel (0,0) on vga_* in cycle N+2.
- Clear end:
  - the last pixel (WIDTH-1, HEIGHT-1) appears on vga_* in the same cycle that `clear_done`=1;
  - `clear_busy` falls in that cycle as well.
- The first requester grant is possible in the cycle `clear_busy` falls.
- Reset asserted mid-sweep: outputs clear immediately (asynchronously), the sweep is aborted, and no `clear_done` is generated.
- Arithmetic: cx is 8 bits and cy is 7 bits; both compare against WIDTH-1 and HEIGHT-1, never against natural overflow.

## Test plan
- Reset, then `food_req`=1 with (85,55,3'b100) for one cycle -> `food_gnt`=1 in that cycle; next cycle vga=(85,55,3'b100) with plot=1; the cycle after, plot=0 and vga holds.
- food and snake both held high for 4 cycles -> grants F,S,F,S; vga shows the alternating pixels with plot=1 for 4 consecutive cycles.
- `clear_start` pulse with colour 3'b000 -> `clear_busy` for 19200 cycles; vga pixels run (0,0),(1,0)...(159,0),(0,1)...(159,119); `clear_done`=1 exactly on (159,119).
- `snake_req` held during the sweep -> `snake_gnt`=0 throughout; granted in the cycle `clear_busy` falls.
- snake request at (160,60) -> `snake_gnt`=1, `vga_plot`=0 next cycle; a following food request is granted normally.
- `reset_n` low at sweep pixel 5000 -> vga/plot/busy go to 0 immediately; no `clear_done`; after release the FSM is in IDLE and a food grant works.
